// File: rtl/fp16_pkg.sv
// Shared binary16 field widths, constants and word layout for the float datapath.
package fp16_pkg;

  localparam int unsigned FP16_BIAS  = 15;
  localparam int unsigned FP16_EXP_W = 5;
  localparam int unsigned FP16_MAN_W = 10;

  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] mant;
  } fp16_t;

  function automatic fp16_t fp16_make(input logic s,
                                      input logic [FP16_EXP_W-1:0] e,
                                      input logic [FP16_MAN_W-1:0] m);
    fp16_t f;
    f.sign = s;
    f.exp  = e;
    f.mant = m;
    return f;
  endfunction

endpackage

// File: rtl/fix2half_lod16.sv
// Combinational leading-one detector for a 16-bit magnitude.
module lod16 (
  input  logic [15:0] d_i,
  output logic [3:0]  p_o,
  output logic        zero_o
);

  // Scan upward so the highest set bit is the one that sticks.
  always_comb begin
    p_o    = '0;
    zero_o = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (d_i[i]) begin
        p_o    = 4'(i);
        zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fix2half.sv
// Signed 16-bit fixed point to binary16, 3-stage valid/ready pipeline.
// Truncating rounding, denormal results flush to zero.
module fix2half
  import fp16_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  localparam logic signed [5:0] EXP_OFS = 6'(int'(FP16_BIAS) - int'(FRAC_BITS));

  // Stage registers
  logic               v1_q, v2_q, v3_q;
  logic               sign1_q;
  logic [15:0]        mag1_q;
  logic               sign2_q;
  logic               zero2_q;
  logic signed [5:0]  exp2_q;
  logic [9:0]         frac2_q;
  fp16_t              data3_q;

  // Next-state / combinational signals
  logic               ready2, ready3;
  logic [15:0]        mag_d;
  logic [3:0]         lod_p;
  logic               lod_zero;
  logic signed [5:0]  exp_d;
  logic [9:0]         frac_d;
  fp16_t              pack_d;

  // Ready chain: a stage can take new content when empty or when its content moves on.
  always_comb begin
    ready3   = !v3_q || out_ready;
    ready2   = !v2_q || ready3;
    in_ready = !v1_q || ready2;
  end

  // S1: sign/magnitude; 0x8000 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    mag_d = in_data[15] ? (~in_data + 16'd1) : in_data;
  end

  lod16 u_lod (
    .d_i    (mag1_q),
    .p_o    (lod_p),
    .zero_o (lod_zero)
  );

  // S2: normalize. The leading one lands just above the 10-bit cast and falls off;
  // bits below the top 10 fraction bits are shifted out (truncation).
  always_comb begin
    exp_d  = $signed({2'b00, lod_p}) + EXP_OFS;
    frac_d = 10'({mag1_q, 16'h0000} >> (5'd6 + 5'(lod_p)));
  end

  // S3: pack, with zero input and non-positive exponent both giving +0.
  always_comb begin
    pack_d = FP16_ZERO;
    if (!zero2_q && (exp2_q > 6'sd0)) begin
      pack_d = fp16_make(sign2_q, exp2_q[4:0], frac2_q);
    end
  end

  // Pipeline registers; data only updates on a real transfer so a stalled output holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      sign1_q <= 1'b0;
      mag1_q  <= '0;
      sign2_q <= 1'b0;
      zero2_q <= 1'b1;
      exp2_q  <= '0;
      frac2_q <= '0;
      data3_q <= FP16_ZERO;
    end else begin
      if (in_ready) begin
        v1_q <= in_valid;
        if (in_valid) begin
          sign1_q <= in_data[15];
          mag1_q  <= mag_d;
        end
      end
      if (ready2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          sign2_q <= sign1_q;
          zero2_q <= lod_zero;
          exp2_q  <= exp_d;
          frac2_q <= frac_d;
        end
      end
      if (ready3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          data3_q <= pack_d;
        end
      end
    end
  end

  always_comb begin
    out_valid = v3_q;
    out_data  = data3_q;
  end

endmodule

// File: tb/tb_fix2half.sv
// Directed bench for fix2half with FRAC_BITS = 8, 0 and 15 instances.
module tb_fix2half;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic [2:0]  iv = '0;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [15:0] od0, od1, od2;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  fix2half #(.FRAC_BITS(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0));

  fix2half #(.FRAC_BITS(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1));

  fix2half #(.FRAC_BITS(15)) u15 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] odat(input int sel);
    case (sel)
      0:       return od0;
      1:       return od1;
      default: return od2;
    endcase
  endfunction

  // One word through instance sel with out_ready high; checks exact 3-stage timing.
  task automatic conv(input int sel, input logic [15:0] din, input logic [15:0] exp,
                      input string tag);
    @(negedge clk);
    in_data = din;
    iv[sel] = 1'b1;
    #1 chk({tag, ".rdy"}, 16'(ir[sel]), 16'd1);
    @(negedge clk);              // accepted at the posedge just passed
    iv[sel] = 1'b0;
    chk({tag, ".v_s1"}, 16'(ov[sel]), 16'd0);
    @(negedge clk);
    chk({tag, ".v_s2"}, 16'(ov[sel]), 16'd0);
    @(negedge clk);
    chk({tag, ".v_out"}, 16'(ov[sel]), 16'd1);
    chk({tag, ".data"}, odat(sel), exp);
    @(negedge clk);
    chk({tag, ".nodup"}, 16'(ov[sel]), 16'd0);
  endtask

  logic [15:0] bp_in  [5];
  logic [15:0] bp_exp [5];

  initial begin
    int unsigned idx, npop, cyc, first_ov;
    int          occ;
    bit          seen;
    bit          acc, pop;

    bp_in  = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
    bp_exp = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};

    // Reset state
    #12;
    for (int s = 0; s < 3; s++) begin
      chk("rst.in_ready", 16'(ir[s]), 16'd1);
      chk("rst.out_valid", 16'(ov[s]), 16'd0);
      chk("rst.out_data", odat(s), 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Basic values and extremes, FRAC_BITS = 8
    conv(0, 16'h0100, 16'h3C00, "one");
    conv(0, 16'hFF00, 16'hBC00, "neg_one");
    conv(0, 16'h0000, 16'h0000, "zero");
    conv(0, 16'h8000, 16'hD800, "min_neg");
    conv(0, 16'h0001, 16'h1C00, "lsb");
    conv(0, 16'h0101, 16'h3C04, "trunc_align");
    conv(0, 16'hFFFF, 16'h9C00, "neg_lsb");
    // FRAC_BITS = 0
    conv(1, 16'h7FFF, 16'h77FF, "fb0_max");
    conv(1, 16'h8000, 16'hF800, "fb0_min");
    // FRAC_BITS = 15
    conv(2, 16'h0001, 16'h0000, "fb15_flush");
    conv(2, 16'h0002, 16'h0400, "fb15_min_norm");

    // Backpressure: stall 5 cycles from first out_valid, then drain in order.
    idx = 0; npop = 0; cyc = 0; first_ov = 0; seen = 0; occ = 0;
    while (npop < 5 && cyc < 40) begin
      @(negedge clk);
      iv[0]     = (idx < 5);
      in_data   = (idx < 5) ? bp_in[idx] : 16'h0000;
      out_ready = seen && (cyc >= first_ov + 5);
      #1;
      if (ov[0] && !seen) begin
        seen      = 1;
        first_ov  = cyc;
        out_ready = 1'b0;
        #1;
      end
      chk("bp.in_ready", 16'(ir[0]), (occ == 3 && !out_ready) ? 16'd0 : 16'd1);
      acc = iv[0] && ir[0];
      pop = ov[0] && out_ready;
      if (pop) begin
        chk("bp.data", od0, bp_exp[npop]);
        npop++;
      end
      if (acc) idx++;
      occ = occ + int'(acc) - int'(pop);
      cyc++;
    end
    chk("bp.count", 16'(npop), 16'd5);
    @(negedge clk);
    iv[0] = 1'b0;
    out_ready = 1'b1;
    #1 chk("bp.empty", 16'(ov[0]), 16'd0);

    // Reset mid-stream with 3 words in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_data = bp_in[k];
      iv[0]   = 1'b1;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    #1 chk("mid.full", 16'(ov[0]), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.out_valid", 16'(ov[0]), 16'd0);
    chk("mid.in_ready", 16'(ir[0]), 16'd1);
    chk("mid.out_data", od0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    conv(0, 16'h0100, 16'h3C00, "post_rst");
    repeat (3) begin
      @(negedge clk);
      chk("post_rst.idle", 16'(ov[0]), 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
